// File: rtl/sha_block_seq.sv
// SHA-256 block sequencer: accepts padded 512-bit blocks, expands the message schedule, drives an external compression core, chains and emits digests.
// Latency: core_start 49 cycles after accept; blk_ready low from accept until capture; a pending digest holds off new blocks until dig_ready.
module sha_block_seq #(
  parameter logic [255:0] HASH_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          abort,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  logic [511:0]  blk_data,
  input  logic          blk_last,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic [255:0]  dig_data,
  output logic          busy,
  output logic          core_start,
  output logic [255:0]  core_H_in,
  output logic [2047:0] core_W,
  input  logic          core_done,
  input  logic [255:0]  core_H_out
);

  typedef enum logic [2:0] {S_IDLE, S_EXPAND, S_START, S_RUN, S_OUT} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [2047:0]  r_w;
  logic [5:0]     r_t;
  logic           r_last;
  logic [255:0]   r_chain;
  logic [255:0]   r_dig;

  logic [5:0]     w_i2, w_i7, w_i15, w_i16;
  logic [31:0]    w_new;
  logic           w_accept;
  logic           w_capture;

  function automatic logic [31:0] f_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Word t lives at bit offset 32*(63-t), which is {~t, 5'b0} for a 6-bit t.
  assign w_i2  = r_t - 6'd2;
  assign w_i7  = r_t - 6'd7;
  assign w_i15 = r_t - 6'd15;
  assign w_i16 = r_t - 6'd16;
  assign w_new = f_s1(r_w[{~w_i2, 5'd0} +: 32]) + r_w[{~w_i7, 5'd0} +: 32]
               + f_s0(r_w[{~w_i15, 5'd0} +: 32]) + r_w[{~w_i16, 5'd0} +: 32];

  assign w_accept  = (r_state == S_IDLE) && blk_valid && !abort;
  assign w_capture = (r_state == S_RUN) && core_done && !abort;

  assign core_H_in = r_chain;
  assign core_W    = r_w;
  assign dig_data  = r_dig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    blk_ready  = 1'b0;
    dig_valid  = 1'b0;
    core_start = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) w_next = S_EXPAND;
      end
      S_EXPAND: if (r_t == 6'd63) w_next = S_START;
      S_START: begin
        core_start = 1'b1;
        w_next     = S_RUN;
      end
      S_RUN: if (core_done) w_next = r_last ? S_OUT : S_IDLE;
      S_OUT: begin
        dig_valid = 1'b1;
        if (dig_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w     <= '0;
      r_t     <= 6'd0;
      r_last  <= 1'b0;
      r_chain <= HASH_IV;
      r_dig   <= '0;
    end else begin
      if (w_accept) begin
        r_w[2047:1536] <= blk_data;
        r_last         <= blk_last;
        r_t            <= 6'd16;
      end else if ((r_state == S_EXPAND) && !abort) begin
        r_w[{~r_t, 5'd0} +: 32] <= w_new;
        r_t                     <= r_t + 6'd1;
      end
      // Abort restarts the message; otherwise the final block re-arms the chain for the next one.
      if (abort) begin
        r_chain <= HASH_IV;
      end else if (w_capture) begin
        if (r_last) begin
          r_dig   <= core_H_out;
          r_chain <= HASH_IV;
        end else begin
          r_chain <= core_H_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha_block_seq.sv
// Directed bench for sha_block_seq with a behavioural one-round-per-cycle SHA-256 compression core.
module tb_sha_block_seq;

  localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          abort = 1'b0;
  logic          blk_valid = 1'b0;
  logic          blk_ready;
  logic [511:0]  blk_data = '0;
  logic          blk_last = 1'b0;
  logic          dig_valid;
  logic          dig_ready = 1'b0;
  logic [255:0]  dig_data;
  logic          busy;
  logic          core_start;
  logic [255:0]  core_H_in;
  logic [2047:0] core_W;
  logic          core_done;
  logic [255:0]  core_H_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sha_block_seq dut (
    .clk(clk), .reset(reset), .abort(abort),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .busy(busy),
    .core_start(core_start), .core_H_in(core_H_in), .core_W(core_W),
    .core_done(core_done), .core_H_out(core_H_out));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] v, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  // Compression core model: reloads on core_start, one round per cycle, done stays high after round 64.
  logic [6:0]   m_cnt = 7'd64;
  logic [255:0] m_v = '0;
  logic [255:0] m_final = '0;
  logic         force_done = 1'b0;
  logic [31:0]  m_wt;

  assign m_wt       = core_W[{~m_cnt[5:0], 5'd0} +: 32];
  assign core_done  = (m_cnt == 7'd64) || force_done;
  assign core_H_out = add8(core_H_in, m_v);

  always @(posedge clk) begin
    if (core_start) begin
      m_cnt <= 7'd0;
      m_v   <= core_H_in;
    end else if (m_cnt < 7'd64) begin
      m_v   <= sha_round(m_v, K[m_cnt[5:0]], m_wt);
      if (m_cnt == 7'd63) m_final <= add8(core_H_in, sha_round(m_v, K[m_cnt[5:0]], m_wt));
      m_cnt <= m_cnt + 7'd1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!blk_ready && n < 300) begin step(); n++; end
    chkb("wait_blk_ready", blk_ready, 1'b1);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!core_start && n < 200) begin step(); n++; end
    chkb("wait_core_start", core_start, 1'b1);
  endtask

  task automatic wait_dig();
    int n = 0;
    while (!dig_valid && n < 300) begin step(); n++; end
    chkb("wait_dig_valid", dig_valid, 1'b1);
  endtask

  task automatic wait_model_done();
    int n = 0;
    while (m_cnt != 7'd64 && n < 200) begin step(); n++; end
    chk("wait_core_rounds", 256'(m_cnt), 256'(64));
  endtask

  task automatic send_block(input logic [511:0] d, input logic last);
    wait_ready();
    blk_data  = d;
    blk_last  = last;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
  endtask

  task automatic pop_digest();
    dig_ready = 1'b1;
    step();
    dig_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [255:0] h1;

    // Reset values while reset is held
    step(); step();
    chkb("rst_blk_ready", blk_ready, 1'b1);
    chkb("rst_dig_valid", dig_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_core_start", core_start, 1'b0);
    chk("rst_dig_data", dig_data, '0);
    chk("rst_chain", core_H_in, IV);
    chk("rst_W", core_W[2047:1792], '0);
    reset = 1'b0;
    step();

    // "abc" with latency and schedule checks
    send_block(ABC_BLK, 1'b1);
    chkb("accept_busy", busy, 1'b1);
    chkb("expand_blk_ready", blk_ready, 1'b0);
    wait_start(n);
    // core_start visible after edge n is sampled by the core on edge n+1
    chk("start_latency", 256'(n + 1), 256'(49));
    chk("first_H_in", core_H_in, IV);
    chk("abc_W0", 256'(core_W[2047:2016]), 256'(32'h61626380));
    chk("abc_W16", 256'(core_W[1535:1504]), 256'(32'h61626380));
    chk("abc_W17", 256'(core_W[1503:1472]), 256'(32'h000f0000));
    step();
    chkb("start_one_cycle", core_start, 1'b0);
    wait_dig();
    chk("abc_digest", dig_data, ABC_DIG);

    // Digest held while dig_ready low; offered block must wait
    blk_data  = ABC_BLK;
    blk_last  = 1'b1;
    blk_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chkb("hold_dig_valid", dig_valid, 1'b1);
      chk("hold_dig_data", dig_data, ABC_DIG);
      chkb("hold_blk_ready", blk_ready, 1'b0);
    end
    dig_ready = 1'b1;
    step();
    dig_ready = 1'b0;
    chkb("pop_dig_valid", dig_valid, 1'b0);
    chkb("pop_not_taken", busy, 1'b0);
    step();
    chkb("taken_next_cycle", busy, 1'b1);
    blk_valid = 1'b0;
    wait_dig();
    chk("abc_digest_2", dig_data, ABC_DIG);
    pop_digest();

    // Two-block message
    send_block(TWO_B1, 1'b0);
    wait_start(n);
    step();
    wait_model_done();
    chkb("pre_capture_ready", blk_ready, 1'b0);
    step();
    chkb("post_capture_ready", blk_ready, 1'b1);
    h1 = m_final;
    send_block(TWO_B2, 1'b1);
    wait_start(n);
    chk("blk2_H_in", core_H_in, h1);
    wait_dig();
    chk("two_digest", dig_data, TWO_DIG);
    pop_digest();

    // Abort during RUN of block 1, abort beats accept, then "abc"
    send_block(TWO_B1, 1'b0);
    wait_start(n);
    for (int i = 0; i < 10; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chkb("abort_busy", busy, 1'b0);
    chkb("abort_ready", blk_ready, 1'b1);
    chkb("abort_dig_valid", dig_valid, 1'b0);
    chk("abort_chain", core_H_in, IV);
    abort     = 1'b1;
    blk_data  = ABC_BLK;
    blk_last  = 1'b1;
    blk_valid = 1'b1;
    step();
    abort     = 1'b0;
    blk_valid = 1'b0;
    chkb("abort_beats_accept", busy, 1'b0);
    send_block(ABC_BLK, 1'b1);
    wait_dig();
    chk("abc_after_abort", dig_data, ABC_DIG);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chkb("abort_in_out", dig_valid, 1'b0);

    // core_done forced high outside RUN
    force_done = 1'b1;
    step(); step(); step();
    chkb("forced_idle_busy", busy, 1'b0);
    chkb("forced_idle_dig", dig_valid, 1'b0);
    send_block(ABC_BLK, 1'b1);
    wait_start(n);
    chk("forced_latency", 256'(n + 1), 256'(49));
    force_done = 1'b0;
    step();
    chkb("forced_in_run", busy, 1'b1);
    chkb("forced_no_capture", dig_valid, 1'b0);
    wait_dig();
    chk("abc_forced", dig_data, ABC_DIG);
    pop_digest();

    // Reset pulse during EXPAND
    send_block(ABC_BLK, 1'b1);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    #1;
    chkb("mid_rst_ready", blk_ready, 1'b1);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_dig_valid", dig_valid, 1'b0);
    chkb("mid_rst_start", core_start, 1'b0);
    chk("mid_rst_dig_data", dig_data, '0);
    chk("mid_rst_chain", core_H_in, IV);
    step();
    reset = 1'b0;
    step();
    send_block(ABC_BLK, 1'b1);
    wait_dig();
    chk("abc_after_reset", dig_data, ABC_DIG);
    pop_digest();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sha_block_seq.md
SHA_BLOCK_SEQ -- requirements
Module: sha_block_seq

Interface
REQ-001 Parameter: HASH_IV, default 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19, initial chaining value (H0 in bits [255:224]).
REQ-002 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 abort  in  1  synchronous abandon of the current message.
REQ-006 blk_valid  in  1  message block offered.
REQ-007 blk_ready  out  1  block accepted when blk_valid&blk_ready at a rising edge.
REQ-008 blk_data  in  512  padded block; word 0 = bits [511:480].
REQ-009 blk_last  in  1  block is the final block of the message.
REQ-010 dig_valid  out  1  digest available.
REQ-011 dig_ready  in  1  digest consumed when dig_valid&dig_ready.
REQ-012 dig_data  out  256  final hash; H0 in bits [255:224].
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 core_start  out  1  one-cycle start pulse; drives the compression core's synchronous reset.
REQ-015 core_H_in  out  256  chaining value to core, H0 in bits [255:224].
REQ-016 core_W  out  2048  expanded schedule; W[0] in bits [2047:2016].
REQ-017 core_done  in  1  core round count reached 64.
REQ-018 core_H_out  in  256  core result (chain + working vars), valid while core_done.

Function
REQ-019 FSM states: IDLE, EXPAND, START, RUN, OUT.
REQ-020 IDLE: blk_ready=1; on accept, W[0..15] <= blk_data, last flag latched, expansion index t <= 16, go EXPAND.
REQ-021 EXPAND: one word per cycle, W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32, s0 = ROTR7^ROTR18^SHR3, s1 = ROTR17^ROTR19^SHR10; after t=63 (48 cycles) go START.
REQ-022 START: core_start=1 for exactly one cycle; next state RUN.
REQ-023 RUN: core_start=0; core_done sampled only in RUN; first cycle core_done=1 captures core_H_out.
REQ-024 On capture with last flag clear: chain <= core_H_out, go IDLE.
REQ-025 On capture with last flag set: dig_data <= core_H_out, chain <= HASH_IV, go OUT.
REQ-026 OUT: dig_valid=1, dig_data stable; on dig_ready go IDLE (dig_valid low next cycle).
REQ-027 core_H_in = chain and core_W = W registers, held constant from START through capture.
REQ-028 core_done ignored outside RUN (stale/wrapped core counter must not trigger capture).
REQ-029 Latency: accept edge -> core_start high 49 cycles later; capture -> blk_ready high the next cycle for non-last blocks.
REQ-030 blk_ready=0 in EXPAND, START, RUN, OUT; no new block accepted while a digest is pending.
REQ-031 abort in any state: next state IDLE, chain <= HASH_IV, dig_valid=0, pending capture discarded; abort wins over simultaneous accept, capture or dig_ready.
REQ-032 All additions modulo 2^32 per word; no carry between words.

Reset
REQ-033 reset asserted: state IDLE, chain = HASH_IV, W registers = 0, last flag 0, dig_data = 0.
REQ-034 Output values during/after reset: blk_ready=1, dig_valid=0, busy=0, core_start=0.
REQ-035 reset mid-operation discards the block in progress; the first accepted block after release starts a new message.

Verification
REQ-036 "abc" single block (blk_last=1) -> dig_data = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; core_start exactly 49 cycles after accept.
REQ-037 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; second-block core_H_in equals first capture.
REQ-038 dig_ready held low 20 cycles in OUT -> dig_valid and dig_data stable, blk_ready=0, offered block not taken until one cycle after dig_ready.
REQ-039 abort during RUN of block 1 of 2, then "abc" -> "abc" digest exact (chain reset to HASH_IV).
REQ-040 core_done forced high during IDLE/EXPAND/START -> no capture, no state change beyond the normal sequence.
REQ-041 reset pulse during EXPAND -> all outputs at reset values, following "abc" hashes correctly.
